// File: rtl/armleocpu_loadgen_queue_if.sv
// Signal bundle between the LSU issue side, the memory read channel and writeback
// for the in-order load tracking queue.
interface armleocpu_loadgen_queue_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_inword_offset;
    logic [2:0]  req_load_type;

    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        mem_rerr;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_missaligned;
    logic        rsp_unknowntype;
    logic        rsp_accessfault;

    modport master (
        output req_valid, req_inword_offset, req_load_type,
        output mem_rvalid, mem_rdata, mem_rerr,
        output rsp_ready,
        input  req_ready, mem_rready,
        input  rsp_valid, rsp_data, rsp_missaligned, rsp_unknowntype, rsp_accessfault
    );

    modport slave (
        input  req_valid, req_inword_offset, req_load_type,
        input  mem_rvalid, mem_rdata, mem_rerr,
        input  rsp_ready,
        output req_ready, mem_rready,
        output rsp_valid, rsp_data, rsp_missaligned, rsp_unknowntype, rsp_accessfault
    );
endinterface

// File: rtl/armleocpu_loadgen_queue.sv
// In-order outstanding-load tracker: aligns and extends each read beat and
// presents the result through a registered valid/ready output stage.
module armleocpu_loadgen_queue #(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    armleocpu_loadgen_queue_if.slave      bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0] offset;
        logic [2:0] load_type;
        logic       err_missaligned;
        logic       err_unknown;
    } entry_t;

    entry_t          q [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    entry_t          head;
    entry_t          new_entry;
    logic            head_err;
    logic            not_empty;
    logic            out_free;
    logic            push;
    logic            beat_pop;
    logic            err_pop;
    logic            pop;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ext_data;

    // Every channel transfers on the cycle where valid && ready are both high
    // at the rising edge; the sender holds its payload stable until then.
    assign head      = q[rd_ptr];
    assign head_err  = head.err_missaligned || head.err_unknown;
    assign not_empty = (count != '0);
    assign out_free  = !bus.rsp_valid || bus.rsp_ready;

    assign bus.req_ready  = (count != CW'(DEPTH));
    assign bus.mem_rready = not_empty && !head_err && out_free;

    assign push     = bus.req_valid && bus.req_ready;
    assign beat_pop = bus.mem_rready && bus.mem_rvalid;
    assign err_pop  = not_empty && head_err && out_free;
    assign pop      = beat_pop || err_pop;

    always_comb begin
        new_entry                 = '0;
        new_entry.offset          = bus.req_inword_offset;
        new_entry.load_type       = bus.req_load_type;
        new_entry.err_unknown     = (bus.req_load_type == 3'b011) ||
                                    (bus.req_load_type == 3'b110) ||
                                    (bus.req_load_type == 3'b111);
        // Only legal types can be misaligned; unknown types report just that.
        new_entry.err_missaligned = !new_entry.err_unknown &&
            (((bus.req_load_type[1:0] == 2'b10) && (bus.req_inword_offset != 2'b00)) ||
             ((bus.req_load_type[1:0] == 2'b01) && bus.req_inword_offset[0]));
    end

    always_comb begin
        byte_sel = bus.mem_rdata[7:0];
        case (head.offset)
            2'd1:    byte_sel = bus.mem_rdata[15:8];
            2'd2:    byte_sel = bus.mem_rdata[23:16];
            2'd3:    byte_sel = bus.mem_rdata[31:24];
            default: byte_sel = bus.mem_rdata[7:0];
        endcase
        half_sel = head.offset[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        ext_data = bus.mem_rdata;
        case (head.load_type)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_data = {24'd0, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_data = {16'd0, half_sel};
            default: ext_data = bus.mem_rdata;
        endcase
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid       <= 1'b0;
            bus.rsp_data        <= '0;
            bus.rsp_missaligned <= 1'b0;
            bus.rsp_unknowntype <= 1'b0;
            bus.rsp_accessfault <= 1'b0;
        end else if (pop) begin
            bus.rsp_valid <= 1'b1;
            if (err_pop) begin
                bus.rsp_data        <= '0;
                bus.rsp_missaligned <= head.err_missaligned;
                bus.rsp_unknowntype <= head.err_unknown;
                bus.rsp_accessfault <= 1'b0;
            end else begin
                bus.rsp_data        <= bus.mem_rerr ? 32'd0 : ext_data;
                bus.rsp_missaligned <= 1'b0;
                bus.rsp_unknowntype <= 1'b0;
                bus.rsp_accessfault <= bus.mem_rerr;
            end
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_armleocpu_loadgen_queue.sv
// Bench for armleocpu_loadgen_queue: directed scenarios followed by a randomized
// run scored against a behavioural model of the load-result rules.
module tb_armleocpu_loadgen_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  armleocpu_loadgen_queue_if bus();

  armleocpu_loadgen_queue #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];
  logic [31:0] beat_data [1024];
  bit          beat_err  [1024];
  int          normal_pushed;
  int          beats_sent;
  bit          hold_prev;
  bit          mem_hold;
  logic [34:0] held;

  // ---------------- clock/reset helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- checkers ----------------
  function automatic logic [34:0] get_rsp();
    return {bus.rsp_data, bus.rsp_missaligned, bus.rsp_unknowntype, bus.rsp_accessfault};
  endfunction

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Result {data, missaligned, unknowntype, accessfault} from the load rules.
  function automatic logic [34:0] model_result(input int off, input int typ,
                                               input logic [31:0] rd, input bit err);
    bit unk;
    bit mis;
    longint v;
    longint scale;
    unk = !(typ inside {0, 1, 2, 4, 5});
    mis = !unk && ((typ == 2 && off != 0) || ((typ == 1 || typ == 5) && (off % 2) == 1));
    if (unk || mis) return {32'd0, mis, unk, 1'b0};
    if (err) return {32'd0, 3'b001};
    scale = longint'(1) << (8 * off);
    v = longint'(rd);
    case (typ)
      0, 4: begin
        v = (v / scale) % 256;
        if (typ == 0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        v = (v / scale) % 65536;
        if (typ == 1 && v >= 32768) v = v - 65536;
      end
      default: ;
    endcase
    return {v[31:0], 3'b000};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic [1:0] off, input logic [2:0] typ);
    bus.req_valid = 1'b1;
    bus.req_inword_offset = off;
    bus.req_load_type = typ;
    #1;
    check_bit("push_ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data, input bit err);
    bit done;
    done = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = data;
    bus.mem_rerr = err;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (bus.mem_rready) done = 1'b1;
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rerr = 1'b0;
    check_bit("beat_accept", done, 1'b1);
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] data,
                            input logic mis, input logic unk, input logic af);
    check_bit({tag, "_valid"}, bus.rsp_valid, 1'b1);
    check(tag, get_rsp(), {data, mis, unk, af});
  endtask

  // One randomized cycle with scoreboard bookkeeping at mid-cycle.
  task automatic rand_cycle(input bit allow_req);
    logic [34:0] r;
    bus.req_valid = allow_req && ($urandom_range(0, 2) != 0);
    bus.req_inword_offset = 2'($urandom_range(0, 3));
    bus.req_load_type = 3'($urandom_range(0, 7));
    bus.rsp_ready = ($urandom_range(0, 3) != 0);
    if (!mem_hold) bus.mem_rvalid = (beats_sent < normal_pushed) && ($urandom_range(0, 2) != 0);
    bus.mem_rdata = beat_data[beats_sent];
    bus.mem_rerr = beat_err[beats_sent];
    #3;
    if (hold_prev) begin
      check_bit("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_data", get_rsp(), held);
    end
    if (beats_sent == normal_pushed) check_bit("rready_idle", bus.mem_rready, 1'b0);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_spurious", 35'(exp_q.size()), 35'd1);
      else check("rsp_order", get_rsp(), exp_q.pop_front());
    end
    if (bus.req_valid && bus.req_ready) begin
      r = model_result(int'(bus.req_inword_offset), int'(bus.req_load_type),
                       beat_data[normal_pushed], beat_err[normal_pushed]);
      exp_q.push_back(r);
      if (r[2:1] == 2'b00) normal_pushed++;
    end
    if (bus.mem_rvalid && bus.mem_rready) beats_sent++;
    hold_prev = bus.rsp_valid && !bus.rsp_ready;
    held = get_rsp();
    mem_hold = bus.mem_rvalid && !bus.mem_rready;
    tick();
  endtask

  // ---------------- directed steps then random run ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_inword_offset = 2'd0;
    bus.req_load_type = 3'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'd0;
    bus.mem_rerr = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check_bit("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp", get_rsp(), 35'd0);
    check_bit("reset_req_ready", bus.req_ready, 1'b1);
    check_bit("reset_mem_rready", bus.mem_rready, 1'b0);
    rst = 1'b0;
    tick();

    // Byte loads with sign and zero extension
    push_req(2'd3, 3'b000);
    send_beat(32'h80FF_1234, 1'b0);
    expect_rsp("lb_o3", 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0);
    push_req(2'd3, 3'b100);
    send_beat(32'h80FF_1234, 1'b0);
    expect_rsp("lbu_o3", 32'h0000_0080, 1'b0, 1'b0, 1'b0);

    // Halfword loads
    push_req(2'd2, 3'b001);
    send_beat(32'h8001_0000, 1'b0);
    expect_rsp("lh_o2", 32'hFFFF_8001, 1'b0, 1'b0, 1'b0);
    push_req(2'd0, 3'b101);
    send_beat(32'h0000_F00D, 1'b0);
    expect_rsp("lhu_o0", 32'h0000_F00D, 1'b0, 1'b0, 1'b0);

    // Fill to DEPTH, then one beat frees exactly one slot
    for (int i = 0; i < 4; i++) push_req(2'd0, 3'b010);
    check_bit("full_req_ready", bus.req_ready, 1'b0);
    send_beat(32'h1111_1111, 1'b0);
    check_bit("after_pop_req_ready", bus.req_ready, 1'b1);
    expect_rsp("full_drain0", 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    push_req(2'd0, 3'b010);
    check_bit("refull_req_ready", bus.req_ready, 1'b0);
    send_beat(32'h2222_2222, 1'b0);
    expect_rsp("full_drain1", 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    send_beat(32'h3333_3333, 1'b0);
    expect_rsp("full_drain2", 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    send_beat(32'h4444_4444, 1'b0);
    expect_rsp("full_drain3", 32'h4444_4444, 1'b0, 1'b0, 1'b0);
    send_beat(32'h5555_5555, 1'b0);
    expect_rsp("full_drain4", 32'h5555_5555, 1'b0, 1'b0, 1'b0);

    // Misaligned entry between two normal loads completes without a beat
    push_req(2'd0, 3'b010);
    push_req(2'd1, 3'b010);
    push_req(2'd0, 3'b000);
    send_beat(32'hA5A5_0001, 1'b0);
    expect_rsp("order_a", 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    check_bit("err_head_rready", bus.mem_rready, 1'b0);
    tick();
    expect_rsp("order_mis", 32'd0, 1'b1, 1'b0, 1'b0);
    send_beat(32'h0000_00F0, 1'b0);
    expect_rsp("order_b", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);

    // Backpressure: output holds, memory stalls, then back-to-back release
    tick();
    bus.rsp_ready = 1'b0;
    push_req(2'd0, 3'b010);
    push_req(2'd0, 3'b010);
    send_beat(32'h1234_5678, 1'b0);
    expect_rsp("bp_first", 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h9ABC_DEF0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", get_rsp(), {32'h1234_5678, 3'b000});
      check_bit("bp_hold_valid", bus.rsp_valid, 1'b1);
      check_bit("bp_rready", bus.mem_rready, 1'b0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_bit("bp_release_rready", bus.mem_rready, 1'b1);
    tick();
    bus.mem_rvalid = 1'b0;
    expect_rsp("bp_second", 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0);
    tick();
    check_bit("bp_idle_valid", bus.rsp_valid, 1'b0);

    // Access fault, unknown type and misaligned halfword
    push_req(2'd0, 3'b010);
    send_beat(32'hDEAD_BEEF, 1'b1);
    expect_rsp("access_fault", 32'd0, 1'b0, 1'b0, 1'b1);
    push_req(2'd0, 3'b110);
    tick();
    expect_rsp("unknown_110", 32'd0, 1'b0, 1'b1, 1'b0);
    push_req(2'd1, 3'b001);
    tick();
    expect_rsp("lh_misaligned", 32'd0, 1'b1, 1'b0, 1'b0);

    // Reset with entries in flight and a valid result
    tick();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_req(2'd0, 3'b010);
    send_beat(32'hCAFE_F00D, 1'b0);
    expect_rsp("pre_reset", 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_bit("mid_reset_valid", bus.rsp_valid, 1'b0);
    check_bit("mid_reset_req_ready", bus.req_ready, 1'b1);
    check_bit("mid_reset_rready", bus.mem_rready, 1'b0);
    rst = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_bit("empty_beat_stall", bus.mem_rready, 1'b0);
      tick();
    end
    check_bit("empty_beat_no_rsp", bus.rsp_valid, 1'b0);
    bus.mem_rvalid = 1'b0;

    // Randomized run against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      beat_data[i] = $urandom;
      beat_err[i] = ($urandom_range(0, 7) == 0);
    end
    normal_pushed = 0;
    beats_sent = 0;
    hold_prev = 1'b0;
    mem_hold = 1'b0;
    held = '0;
    tick();
    for (int i = 0; i < 700; i++) rand_cycle(1'b1);
    for (int i = 0; i < 80; i++) rand_cycle(1'b0);
    check("drain_empty", 35'(exp_q.size()), 35'd0);
    check("beats_all_used", 35'(beats_sent), 35'(normal_pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
